// File: rtl/clkdiv_cfg_ctrl.sv
// Glitch-free run-time ratio/enable sequencer for the integer clock divider.
// Gates the divider on a divided-clock falling edge, loads the new ratio, then re-enables it.
module clkdiv_cfg_ctrl #(
  parameter int DIVIDED_RATIO_WIDTH = 4,
  parameter int DEFAULT_RATIO       = 1,
  parameter int GUARD_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES      = 32
) (
  input  logic                           i_ref_clk,
  input  logic                           i_rst_n,
  input  logic                           i_cfg_valid,
  output logic                           o_cfg_ready,
  input  logic [DIVIDED_RATIO_WIDTH-1:0] i_cfg_ratio,
  input  logic                           i_cfg_en,
  input  logic                           i_div_clk,
  output logic                           o_clk_en,
  output logic [DIVIDED_RATIO_WIDTH-1:0] o_div_ratio,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_timeout
);

  localparam int W  = DIVIDED_RATIO_WIDTH;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = 4;

  localparam logic [W-1:0]  RATIO_RST = W'(DEFAULT_RATIO);
  localparam logic [W-1:0]  RATIO_ONE = W'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    GATE,
    LOAD,
    ENABLE
  } state_t;

  state_t          state, state_d;
  logic            div_clk_q;
  logic [WW-1:0]   wait_cnt, wait_cnt_d;
  logic [GW-1:0]   gate_cnt, gate_cnt_d;
  logic [W-1:0]    cap_ratio, cap_ratio_d;
  logic            cap_en, cap_en_d;
  logic            clk_en_d, done_d, err_d, timeout_d;
  logic [W-1:0]    ratio_d;
  logic            accept, fall;

  assign accept = i_cfg_valid & o_cfg_ready;
  assign fall   = div_clk_q & ~i_div_clk;

  always_comb begin
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    gate_cnt_d  = gate_cnt;
    cap_ratio_d = cap_ratio;
    cap_en_d    = cap_en;
    clk_en_d    = o_clk_en;
    ratio_d     = o_div_ratio;
    done_d      = 1'b0;
    err_d       = 1'b0;
    timeout_d   = o_timeout;
    case (state)
      IDLE: begin
        wait_cnt_d = '0;
        gate_cnt_d = '0;
        if (accept) begin
          if (i_cfg_ratio == '0) begin
            err_d = 1'b1;
          end else begin
            timeout_d   = 1'b0;
            cap_ratio_d = i_cfg_ratio;
            cap_en_d    = i_cfg_en;
            // At ratio 1 the divider output is combinational, so there is no edge to wait for.
            if (!o_clk_en)                     state_d = LOAD;
            else if (o_div_ratio == RATIO_ONE) state_d = GATE;
            else                               state_d = WAIT_EDGE;
          end
        end
      end
      WAIT_EDGE: begin
        wait_cnt_d = wait_cnt + 1'b1;
        if (fall) begin
          clk_en_d = 1'b0;
          state_d  = GATE;
        end else if (wait_cnt == WAIT_LAST) begin
          clk_en_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = GATE;
        end
      end
      GATE: begin
        // Guard cycles count only once the enable is actually low (bypass entry drops it here).
        if (o_clk_en)                   clk_en_d   = 1'b0;
        else if (gate_cnt == GATE_LAST) state_d    = LOAD;
        else                            gate_cnt_d = gate_cnt + 1'b1;
      end
      LOAD: begin
        ratio_d = cap_ratio;
        state_d = ENABLE;
      end
      ENABLE: begin
        clk_en_d = cap_en;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      div_clk_q   <= 1'b0;
      wait_cnt    <= '0;
      gate_cnt    <= '0;
      cap_ratio   <= RATIO_RST;
      cap_en      <= 1'b0;
      o_cfg_ready <= 1'b1;
      o_clk_en    <= 1'b0;
      o_div_ratio <= RATIO_RST;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_d;
      div_clk_q   <= i_div_clk;
      wait_cnt    <= wait_cnt_d;
      gate_cnt    <= gate_cnt_d;
      cap_ratio   <= cap_ratio_d;
      cap_en      <= cap_en_d;
      o_cfg_ready <= (state_d == IDLE);
      o_clk_en    <= clk_en_d;
      o_div_ratio <= ratio_d;
      o_busy      <= (state_d != IDLE);
      o_done      <= done_d;
      o_err       <= err_d;
      o_timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: timeline model of each update plus directed latency/literal checks.
// A small stand-in divider closes the i_div_clk feedback loop.
module tb_clkdiv_cfg_ctrl;
  localparam int W  = 4;
  localparam int G  = 2;
  localparam int TO = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] cfg_ratio = '0;
  logic         cfg_en = 1'b0;
  logic         div_clk;
  logic         o_cfg_ready, o_clk_en, o_busy, o_done, o_err, o_timeout;
  logic [W-1:0] o_div_ratio;

  int total = 0;
  int bad   = 0;

  clkdiv_cfg_ctrl #(
    .DIVIDED_RATIO_WIDTH(W), .DEFAULT_RATIO(1), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_ref_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_ratio(cfg_ratio), .i_cfg_en(cfg_en), .i_div_clk(div_clk), .o_clk_en(o_clk_en),
    .o_div_ratio(o_div_ratio), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Stand-in divider: high for ratio/2 cycles per period, held low when gated or at ratio 1.
  logic [W-1:0] dcnt = '0;
  logic         dclk = 1'b0;
  logic         force_hi = 1'b0;
  always @(posedge clk) begin
    if (!o_clk_en || o_div_ratio < W'(2)) begin
      dcnt <= '0;
      dclk <= 1'b0;
    end else begin
      dcnt <= (dcnt == o_div_ratio - W'(1)) ? '0 : dcnt + W'(1);
      dclk <= (dcnt < (o_div_ratio >> 1));
    end
  end
  assign div_clk = force_hi | dclk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Model: each accepted update becomes a set of absolute cycle numbers for its events.
  int           mcyc = 0, t_acc = 0, t_drop = -1, t_load = -1, t_fin = -1;
  bit           m_busy = 0, m_en = 0, m_done = 0, m_err = 0, m_to = 0;
  bit           waiting = 0, prev_div = 0, cap_en = 0;
  logic [W-1:0] m_ratio = W'(1), cap_r = W'(1);

  initial forever begin
    bit idle, fall;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_ratio = W'(1); m_done = 0; m_err = 0; m_to = 0;
      waiting = 0; prev_div = 0; t_drop = -1; t_load = -1; t_fin = -1;
    end else begin
      mcyc++;
      idle   = !m_busy;
      m_done = 0;
      m_err  = 0;
      fall   = prev_div && !div_clk;
      if (!idle) begin
        if (waiting && (fall || (mcyc - t_acc) == TO)) begin
          m_en = 0;
          if (!fall) m_to = 1;
          t_load  = mcyc + G + 1;
          t_fin   = mcyc + G + 2;
          waiting = 0;
        end
        if (mcyc == t_drop) m_en = 0;
        if (mcyc == t_load) m_ratio = cap_r;
        if (mcyc == t_fin) begin
          m_en = cap_en; m_done = 1; m_busy = 0;
        end
      end else if (valid) begin
        if (cfg_ratio == '0) begin
          m_err = 1;
        end else begin
          m_to = 0; cap_r = cfg_ratio; cap_en = cfg_en; m_busy = 1; t_acc = mcyc;
          t_drop = -1; t_load = -1; t_fin = -1;
          if (!m_en) begin
            t_load = mcyc + 1; t_fin = mcyc + 2;
          end else if (m_ratio == W'(1)) begin
            t_drop = mcyc + 1; t_load = mcyc + G + 2; t_fin = mcyc + G + 3;
          end else begin
            waiting = 1;
          end
        end
      end
      prev_div = div_clk;
    end
  end

  // Every in-reset-free cycle the whole output vector must match the model.
  logic [W+5:0] exp_v, act_v;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      exp_v = {!m_busy, m_en, m_ratio, m_busy, m_done, m_err, m_to};
      act_v = {o_cfg_ready, o_clk_en, o_div_ratio, o_busy, o_done, o_err, o_timeout};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got=%b want=%b (rdy,en,ratio,busy,done,err,to)",
                 $time, act_v, exp_v);
      end
    end
  end

  // Divided-clock high pulses must never be clipped while a live change is in flight.
  bit pw_on = 0;
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (div_clk) run++;
      else begin
        if (run > 0 && pw_on) begin
          total++;
          if (run * 10 < 20) begin
            bad++;
            $display("FAIL div_high_pulse got=%0dns want>=20ns", run * 10);
          end
        end
        run = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] r, input logic e, output int waited);
    bit acc;
    waited = 0;
    acc = 0;
    @(negedge clk);
    valid = 1'b1; cfg_ratio = r; cfg_en = e;
    while (!acc && waited < 200) begin
      acc = o_cfg_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    valid = 1'b0;
    if (!acc) chk("accept_bound", 0, 1);
  endtask

  // Called at accept+1ns; returns cycles from the accept edge to the o_done edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_done) chk("done_bound", 0, 1);
  endtask

  initial begin
    int w, w2, lat, lowc, n, last, per;
    bit prev;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_en", o_clk_en, 0);
    chk("rst_ratio", o_div_ratio, 1);
    chk("rst_ready", o_cfg_ready, 1);
    chk("rst_busy", o_busy, 0);
    @(negedge clk); rst_n = 1'b1;

    // Disabled load: ratio at T1, enable and done at T2.
    send(4, 1, w);
    @(posedge clk); #1;
    chk("dis_ratio_T1", o_div_ratio, 4);
    chk("dis_en_T1", o_clk_en, 0);
    @(posedge clk); #1;
    chk("dis_en_T2", o_clk_en, 1);
    chk("dis_done_T2", o_done, 1);
    chk("dis_ready_T2", o_cfg_ready, 1);
    last = -1; per = 0;
    for (int i = 0; i < 20; i++) begin
      prev = div_clk;
      @(posedge clk); #1;
      if (!prev && div_clk) begin
        if (last >= 0 && per == 0) per = i - last;
        last = i;
      end
    end
    chk("div_period_ns", per * 10, 40);

    // Live change 4 -> 6: enable low from the fall edge through re-enable (guard + load + enable).
    pw_on = 1;
    send(6, 1, w);
    lowc = 0; n = 0;
    while (!o_done && n < 200) begin
      if (!o_clk_en) lowc++;
      @(posedge clk); #1;
      n++;
    end
    chk("live_done_seen", o_done, 1);
    chk("live_low_cycles", lowc, G + 2);
    chk("live_ratio", o_div_ratio, 6);
    repeat (14) @(posedge clk);
    pw_on = 0;

    // Rejected request leaves the divider alone.
    send(0, 1, w);
    chk("err_pulse", o_err, 1);
    chk("err_ratio", o_div_ratio, 6);
    chk("err_en", o_clk_en, 1);
    chk("err_busy", o_busy, 0);

    // Backpressure: second request waits for the first to finish.
    send(2, 1, w);
    chk("bp_ready_low", o_cfg_ready, 0);
    send(6, 1, w2);
    chk("bp_waited", (w2 > 0) ? 1 : 0, 1);
    wait_done(lat);
    chk("bp_final_ratio", o_div_ratio, 6);

    // Timeout with the divided clock stuck high.
    repeat (3) @(posedge clk);
    @(negedge clk); force_hi = 1'b1;
    send(3, 1, w);
    wait_done(lat);
    chk("to_latency", lat, TO + G + 2);
    chk("to_flag", o_timeout, 1);
    chk("to_ratio", o_div_ratio, 3);
    @(negedge clk); force_hi = 1'b0;
    repeat (4) @(posedge clk);
    send(1, 1, w);
    chk("to_cleared", o_timeout, 0);
    wait_done(lat);

    // Ratio-1 bypass straight into the guard.
    repeat (3) @(posedge clk);
    send(5, 1, w);
    wait_done(lat);
    chk("bypass_latency", lat, G + 3);
    chk("bypass_ratio", o_div_ratio, 5);

    // Enable=0 request still completes and leaves the divider gated.
    send(7, 0, w);
    wait_done(lat);
    chk("en0_clk_en", o_clk_en, 0);
    chk("en0_ratio", o_div_ratio, 7);

    // Asynchronous reset in the middle of the guard.
    send(4, 1, w);
    wait_done(lat);
    chk("dis_latency", lat, 2);
    repeat (3) @(posedge clk);
    send(2, 1, w);
    n = 0;
    while (!(o_busy && !o_clk_en) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gate_reached", (o_busy && !o_clk_en) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", o_clk_en, 0);
    chk("arst_ratio", o_div_ratio, 1);
    chk("arst_busy", o_busy, 0);
    chk("arst_ready", o_cfg_ready, 1);
    chk("arst_done", o_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(5, 1, w);
    wait_done(lat);
    chk("post_rst_latency", lat, 2);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=expired want=finished");
    $fatal(1);
  end
endmodule
